gf256_row_normalizer: RTL and testbench

- Streaming controller that normalizes one matrix row over GF(256) (AES polynomial x^8+x^4+x^3+x+1) for the Gaussian-elimination datapath.
- The first byte of the row is the pivot. The block latches the pivot's inverse from one inv256 lookup, then sequences one shared GF(256) multiplier across the remaining row bytes.
- Sits between the row buffer (input stream) and the elimination engine (output stream). Both streams use valid/ready.

---
 rtl/gf256_row_normalizer.sv | 154 +++++++++++++++
 tb/tb_gf256_row_normalizer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gf256_row_normalizer.sv
// Normalizes one GF(256) matrix row: latches inv(pivot) from the first byte, then
// scales every following byte by that inverse through one shared multiplier.
module gf256_row_normalizer #(
  parameter int LEN   = 16,
  parameter int CNT_W = $clog2(LEN)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  output logic       busy_o,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_last_o,
  output logic       singular_o,
  output logic       done_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PIVOT = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

  // Shift-and-add multiply, reducing by x^8+x^4+x^3+x+1 after every shift.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128; zero maps to 0x01 so singular rows pass through.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] acc;
    p   = gf_mul(a, a);
    acc = p;
    for (int i = 0; i < 6; i++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return (a == 8'h00) ? 8'h01 : acc;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       inv_q, inv_d;
  logic             sing_q, sing_d;
  logic [7:0]       odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic             olast_q, olast_d;

  logic       accepting;
  logic       in_hs;
  logic       out_hs;
  logic       is_last;
  logic [7:0] piv_inv;
  logic [7:0] mul_b;
  logic [7:0] mul_out;

  assign accepting = (state_q == S_PIVOT) || (state_q == S_SCALE);
  assign in_ready_o = accepting && (!ovalid_q || out_ready_i);
  assign in_hs   = in_valid_i && in_ready_o;
  assign out_hs  = ovalid_q && out_ready_i;
  assign is_last = (cnt_q == LAST_IDX);

  // The pivot byte is scaled by its own freshly computed inverse, giving 0x01 (or 0x00).
  assign piv_inv = gf_inv(in_data_i);
  assign mul_b   = (state_q == S_PIVOT) ? piv_inv : inv_q;
  assign mul_out = gf_mul(in_data_i, mul_b);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    sing_d   = sing_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_PIVOT;
          cnt_d   = '0;
          sing_d  = 1'b0;
        end
      end
      S_PIVOT: begin
        if (in_hs) begin
          state_d = S_SCALE;
          inv_d   = piv_inv;
          sing_d  = (in_data_i == 8'h00);
        end
      end
      S_SCALE: begin
        if (in_hs && is_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_hs && olast_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Counter saturates at the last index so it never wraps inside a row.
    if (in_hs && !is_last) cnt_d = cnt_q + CNT_W'(1);

    if (in_hs) begin
      odata_d  = mul_out;
      ovalid_d = 1'b1;
      olast_d  = is_last;
    end else if (out_hs) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      inv_q    <= 8'h01;
      sing_q   <= 1'b0;
      odata_q  <= 8'h00;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      inv_q    <= inv_d;
      sing_q   <= sing_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign out_data_o  = odata_q;
  assign out_valid_o = ovalid_q;
  assign out_last_o  = olast_q;
  assign singular_o  = sing_q;
  assign done_o      = (state_q == S_DRAIN) && out_hs && olast_q;

endmodule

// File: tb/tb_gf256_row_normalizer.sv
// Randomized and directed bench for gf256_row_normalizer against a polynomial GF(256) model.
module tb_gf256_row_normalizer;
  localparam int LEN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, busy;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_last;
  logic       singular, done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] row_q [LEN];
  logic [7:0] obs   [LEN];

  gf256_row_normalizer #(.LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_last_o(out_last), .singular_o(singular), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Carry-less product, then long division by 0x11B.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  // Brute-force search for the multiplicative inverse; 0 maps to 1.
  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    if (a == 8'h00) return 8'h01;
    for (int b = 1; b < 256; b++) if (ref_mul(a, 8'(b)) == 8'h01) return 8'(b);
    return 8'h00;
  endfunction

  // mode 0: always valid/ready; 1: random gaps and stray starts; 2: 3-cycle stall on first output
  task automatic run_row(input int mode);
    logic [7:0] exp_q [LEN];
    logic [7:0] inv, prev_data;
    int  sent = 0, got = 0, hold = 0, cyc = 0;
    bit  hold_done = 0, fin = 0, prev_stall = 0;
    inv = ref_inv(row_q[0]);
    for (int i = 0; i < LEN; i++) exp_q[i] = ref_mul(row_q[i], inv);

    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("idle_before_start", busy, 0);
    chk("no_stale_valid", out_valid, 0);

    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mode == 2 && !hold_done && out_valid) begin hold = 3; hold_done = 1; end
      in_valid  = (sent < LEN) && (mode != 1 || $urandom_range(3) != 0);
      in_data   = (sent < LEN) ? row_q[sent] : 8'($urandom);
      out_ready = (mode == 1) ? ($urandom_range(2) != 0) : (hold == 0);
      start     = (mode == 1) && ($urandom_range(5) == 0);
      #1;
      if (cyc == 1) begin
        chk("busy_after_start", busy, 1);
        chk("singular_cleared", singular, 0);
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (hold > 0) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_data", out_data, 8'h01);
        hold--;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk($sformatf("out_data[%0d]", got), out_data, exp_q[got]);
        chk($sformatf("out_last[%0d]", got), out_last, (got == LEN - 1));
        chk($sformatf("done[%0d]", got), done, (got == LEN - 1));
        obs[got] = out_data;
        got++;
        if (got == LEN) begin
          fin = 1;
          chk("singular_flag", singular, (row_q[0] == 8'h00));
          chk("sent_count", sent, LEN);
        end
      end else begin
        chk("done_quiet", done, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    if (!fin) chk("row_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n, input logic exp_sing);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
      #1;
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_singular", singular, exp_sing);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_singular", singular, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    row_q = '{8'h02, 8'h03, 8'h04, 8'h05};
    run_row(0);
    chk("r1_b0", obs[0], 8'h01);
    chk("r1_b1", obs[1], 8'h8C);
    chk("r1_b2", obs[2], 8'h02);
    chk("r1_b3", obs[3], 8'h8F);

    row_q = '{8'h00, 8'h07, 8'h09, 8'hFF};
    run_row(0);
    chk("r2_b0", obs[0], 8'h00);
    chk("r2_b3", obs[3], 8'hFF);
    idle_cycles(3, 1'b1);

    row_q = '{8'h53, 8'h01, 8'h00, 8'hCA};
    run_row(0);
    chk("r3_b1", obs[1], 8'hCA);
    chk("r3_b2", obs[2], 8'h00);

    row_q = '{8'h02, 8'h03, 8'h04, 8'h05};
    run_row(2);
    chk("bp_b0", obs[0], 8'h01);
    chk("bp_b1", obs[1], 8'h8C);
    chk("bp_b2", obs[2], 8'h02);
    chk("bp_b3", obs[3], 8'h8F);

    // back-to-back rows with random gaps and stray starts while busy
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < LEN; i++) row_q[i] = 8'($urandom);
      if ($urandom_range(3) == 0) row_q[0] = 8'h00;
      run_row(1);
    end
    idle_cycles(2, (row_q[0] == 8'h00));

    // reset in the middle of a row
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk); in_data = 8'h22;
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_last", out_last, 0);
    @(negedge clk); rst_n = 1'b1;

    row_q = '{8'h01, 8'hAA, 8'hBB, 8'hCC};
    run_row(0);
    chk("post_rst_b0", obs[0], 8'h01);
    chk("post_rst_b1", obs[1], 8'hAA);
    chk("post_rst_b2", obs[2], 8'hBB);
    chk("post_rst_b3", obs[3], 8'hCC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
